// File: rtl/if_id_pipe.sv
// if_id_pipe: IF->ID pipeline register with valid/ready handshake, a
// two-entry skid buffer, synchronous flush and a saturating stall counter.
// in_ready and out_valid are decoded from the occupancy register alone, so
// decode backpressure never forms a combinational path back into fetch.
module if_id_pipe #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy doubles as the state encoding.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    occ_e              occ_q, occ_d;
    logic [ADDR_W-1:0] main_pc_q, main_pc_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d;
    logic [ADDR_W-1:0] skid_pc_q;
    logic [INST_W-1:0] skid_inst_q;
    logic              skid_load;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              accept;
    logic              fire;

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    // State register: occupancy and the main (output-facing) entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q       <= EMPTY;
            main_pc_q   <= '0;
            main_inst_q <= NOP_INST;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values, so block order cannot change behaviour.
            occ_q       <= occ_d;
            main_pc_q   <= main_pc_d;
            main_inst_q <= main_inst_d;
        end
    end

    // Skid entry: written only when a second entry arrives while the first is held.
    always_ff @(posedge clk) begin
        // NOTE: no reset here on purpose; the skid entry is only read in FULL, which is reachable only after it has been written.
        if (skid_load) begin
            skid_pc_q   <= in_pc;
            skid_inst_q <= in_inst;
        end
    end

    // Next-state logic: flush overrides the handshake; EMPTY always carries a cleared main entry.
    always_comb begin
        // NOTE: defaulting every output of this block first means no path leaves a signal unassigned, so no latch is inferred.
        occ_d       = occ_q;
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        skid_load   = 1'b0;

        if (flush) begin
            occ_d       = EMPTY;
            main_pc_d   = '0;
            main_inst_d = NOP_INST;
        end else begin
            unique case (occ_q)
                EMPTY: begin
                    if (accept) begin
                        occ_d       = ONE;
                        main_pc_d   = in_pc;
                        main_inst_d = in_inst;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        main_pc_d   = in_pc;
                        main_inst_d = in_inst;
                    end else if (accept) begin
                        occ_d     = FULL;
                        skid_load = 1'b1;
                    end else if (fire) begin
                        occ_d       = EMPTY;
                        main_pc_d   = '0;
                        main_inst_d = NOP_INST;
                    end
                end
                FULL: begin
                    if (fire) begin
                        occ_d       = ONE;
                        main_pc_d   = skid_pc_q;
                        main_inst_d = skid_inst_q;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean empty pipe.
                    occ_d       = EMPTY;
                    main_pc_d   = '0;
                    main_inst_d = NOP_INST;
                end
            endcase
        end
    end

    // Output decode: handshake flags depend only on registered occupancy.
    always_comb begin
        out_valid = (occ_q != EMPTY);
        in_ready  = (occ_q != FULL);
        out_pc    = main_pc_q;
        out_inst  = main_inst_q;
        occupancy = occ_q;
    end

    // Stall counter: cycles where decode refuses a valid entry, saturating; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// tb_if_id_pipe: directed self-checking bench for if_id_pipe. A narrow stall
// counter and a non-zero NOP value make saturation and the cleared-entry
// value observable.
module tb_if_id_pipe;

    localparam int                ADDR_W = 32;
    localparam int                INST_W = 32;
    localparam int                CNT_W  = 4;
    localparam logic [INST_W-1:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [INST_W-1:0] in_inst;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    if_id_pipe #(
        .ADDR_W  (ADDR_W),
        .INST_W  (INST_W),
        .NOP_INST(NOP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_inst  (in_inst),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_inst (out_inst),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot against expected values.
    task automatic check_out(input string tag, input logic v, input logic [ADDR_W-1:0] pc,
                             input logic [INST_W-1:0] inst, input logic [1:0] occ,
                             input logic rdy);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
        check({tag, ".out_pc"},    64'(out_pc),    64'(pc));
        check({tag, ".out_inst"},  64'(out_inst),  64'(inst));
        check({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
        check({tag, ".in_ready"},  64'(in_ready),  64'(rdy));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h100;
        in_inst   = 32'hDEAD_BEEF;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset held two cycles with a valid input present: input ignored.
        tick();
        tick();
        check_out("reset", 1'b0, '0, NOP, 2'd0, 1'b1);
        check("reset.stall_cnt", 64'(stall_cnt), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Streaming with out_ready held high: one cycle latency, occupancy 1.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'(4 * i);
            in_inst  = 32'h2001_0001 + 32'(i);
            tick();
            check_out($sformatf("stream%0d", i), 1'b1, 32'(4 * i),
                      32'h2001_0001 + 32'(i), 2'd1, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check_out("stream_drain", 1'b0, '0, NOP, 2'd0, 1'b1);
        check("stream.stall_cnt", 64'(stall_cnt), 64'd0);

        // Backpressure: 0x0 and 0x4 accepted, 0x8 held at the input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h0;
        in_inst   = 32'hA0;
        tick();
        check_out("bp_a", 1'b1, 32'h0, 32'hA0, 2'd1, 1'b1);
        in_pc   = 32'h4;
        in_inst = 32'hA1;
        tick();
        check_out("bp_b", 1'b1, 32'h0, 32'hA0, 2'd2, 1'b0);
        check("bp_b.stall_cnt", 64'(stall_cnt), 64'd1);
        in_pc   = 32'h8;
        in_inst = 32'hA2;
        tick();
        check_out("bp_c", 1'b1, 32'h0, 32'hA0, 2'd2, 1'b0);
        check("bp_c.stall_cnt", 64'(stall_cnt), 64'd2);
        tick();
        check_out("bp_d", 1'b1, 32'h0, 32'hA0, 2'd2, 1'b0);
        check("bp_d.stall_cnt", 64'(stall_cnt), 64'd3);
        out_ready = 1'b1;
        tick();
        check_out("bp_e", 1'b1, 32'h4, 32'hA1, 2'd1, 1'b1);
        check("bp_e.stall_cnt", 64'(stall_cnt), 64'd3);
        tick();
        check_out("bp_f", 1'b1, 32'h8, 32'hA2, 2'd1, 1'b1);
        in_valid = 1'b0;
        tick();
        check_out("bp_g", 1'b0, '0, NOP, 2'd0, 1'b1);

        // Flush from FULL with a new input in the flush cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h20;
        in_inst   = 32'hB0;
        tick();
        in_pc   = 32'h24;
        in_inst = 32'hB1;
        tick();
        check_out("fl_full", 1'b1, 32'h20, 32'hB0, 2'd2, 1'b0);
        check("fl_full.stall_cnt", 64'(stall_cnt), 64'd4);
        flush   = 1'b1;
        in_pc   = 32'h40;
        in_inst = 32'hB2;
        tick();
        check_out("fl_a", 1'b0, '0, NOP, 2'd0, 1'b1);
        check("fl_a.stall_cnt", 64'(stall_cnt), 64'd5);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check_out("fl_b", 1'b0, '0, NOP, 2'd0, 1'b1);

        // Flush from EMPTY while in_ready=1: the input is still dropped.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h44;
        in_inst  = 32'hB3;
        tick();
        check_out("fl_empty", 1'b0, '0, NOP, 2'd0, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check_out("fl_empty_after", 1'b0, '0, NOP, 2'd0, 1'b1);

        // Simultaneous accept and fire while holding one entry.
        in_valid = 1'b1;
        in_pc    = 32'h10;
        in_inst  = 32'hC0;
        tick();
        check_out("af_a", 1'b1, 32'h10, 32'hC0, 2'd1, 1'b1);
        in_pc     = 32'h14;
        in_inst   = 32'hC1;
        out_ready = 1'b1;
        tick();
        check_out("af_b", 1'b1, 32'h14, 32'hC1, 2'd1, 1'b1);
        in_valid = 1'b0;
        tick();
        check_out("af_c", 1'b0, '0, NOP, 2'd0, 1'b1);
        check("af.stall_cnt", 64'(stall_cnt), 64'd5);

        // Counter saturation: 20 stalled cycles from 5 reach 15 and hold.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h80;
        in_inst   = 32'hD0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 8) check("sat_14", 64'(stall_cnt), 64'd14);
            if (i == 9) check("sat_15", 64'(stall_cnt), 64'd15);
        end
        check("sat_hold", 64'(stall_cnt), 64'd15);
        check_out("sat_out", 1'b1, 32'h80, 32'hD0, 2'd1, 1'b1);

        // Reset mid-operation discards the held entry and clears the counter.
        rst = 1'b1;
        tick();
        check_out("rst_mid", 1'b0, '0, NOP, 2'd0, 1'b1);
        check("rst_mid.stall_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
        tick();
        check_out("rst_after", 1'b0, '0, NOP, 2'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
